count_direction_decoder: RTL and testbench
==========================================

Name: count_direction_decoder

Overview:
- Receive-side companion to the 2-bit up/down (divide-by-4) counter.
- Watches the counter's 2-bit output code and recovers the direction of each step, using the same encoding as the counter's direction input (0 = up, 1 = down).
- Keeps a signed position total and flags illegal jumps of two codes in one sample.
- Sits downstream of the counter, in the same clock domain or behind an optional synchroniser.

Parameters:
- POS_W, 16, width of the signed two's-complement position accumulator (minimum 4).
- SATURATE, 1, 1 = position clamps at its signed min/max; 0 = position wraps modulo 2^POS_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- count_in  in  2  code from the up/down counter, {Q_B, Q_A}.
- clear  in  1  synchronous clear of position, overflow and fault; active-high.
- locked  out  1  high once a reference code has been captured and the block is tracking.
- step_valid  out  1  one-cycle pulse for each legal step detected.
- dir  out  1  direction of the last legal step (0 = up, 1 = down); holds between steps.
- position  out  POS_W  signed net step count since the last reset or clear.
- overflow  out  1  sticky; set when position hits a limit (SATURATE=1) or wraps (SATURATE=0).
- error  out  1  high while in FAULT.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, last_code=0, locked=0, step_valid=0, dir=0, position=0, overflow=0, error=0.
- Code path: count_in is compared directly, or code_s when CODE_SYNC_EN is defined. All outputs are registered.
- Latency: an input change sampled at edge N appears on the outputs after edge N (one cycle).
- States: IDLE, TRACK, FAULT.
- IDLE:
  - First edge with reset=1: last_code <= code, go to TRACK, locked <= 1.
  - No step_valid in this cycle.
- TRACK: delta = (code - last_code) mod 4, then last_code <= code.
  - delta 0: hold; step_valid=0.
  - delta 1: position+1, dir<=0, step_valid=1.
  - delta 3: position-1, dir<=1, step_valid=1.
  - delta 2: go to FAULT, error<=1, locked<=0, step_valid=0, position held.
- FAULT:
  - Outputs held, step_valid=0, input ignored.
  - Only clear (or reset) exits.
- clear, in any state:
  - Next state IDLE; position<=0, overflow<=0, error<=0, locked<=0, step_valid=0.
  - dir is held.
  - clear has priority over a step sampled in the same cycle.
- Wrap of the input code: 3->0 is up and 0->3 is down (modular delta). This is not a boundary case.
- Position limits:
  - SATURATE=1: +1 at 2^(POS_W-1)-1 or -1 at -2^(POS_W-1) leaves position unchanged and sets overflow. step_valid and dir still update.
  - SATURATE=0: position wraps and overflow is set.
- Reset asserted mid-operation clears everything immediately, regardless of state.

Optional Feature:
- Macro: CODE_SYNC_EN.
- Defined: count_in passes through a 2-flop synchroniser per bit before comparison. Latency becomes 3 cycles; the sync flops reset to 0.
- Not defined: count_in is sampled directly, with 1-cycle latency. The counter must then share clk.

Decomposition:
- Package count_dir_pkg contains:
  - typedef enum logic [1:0] {IDLE, TRACK, FAULT} dec_state_t.
  - localparams DIR_UP=1'b0, DIR_DOWN=1'b1, CODE_W=2.
  - Function code_delta(a, b) returning the 2-bit modular difference.
- One sub-module: count_sync2, a 2-flop synchroniser with async active-low reset. It is instantiated only under CODE_SYNC_EN.

Test Plan:
- Reset release with count_in=2: one cycle later locked=1, position=0, no step_valid.
- Up sequence from 2 -> 3,0,1,2 on successive cycles: four step_valid pulses, dir=0, position=4.
- Then down sequence 2 -> 1,0,3: three pulses, dir=1, position=1. Then hold 3 for 5 cycles: no pulses, position=1.
- From code 1, jump to 3: error=1, locked=0, position frozen at its prior value. Further steps are ignored. Pulse clear: position=0, error=0; locked returns one cycle later.
- POS_W=4, SATURATE=1:
  - Nine up steps: position stops at 7, overflow=1, nine step_valid pulses.
  - With SATURATE=0, the same stimulus gives position=-7 and overflow=1.
- Assert reset mid-way through an up sequence at position=5: all outputs return to 0 at once. After release, IDLE re-captures the code with no spurious step.

Source files
------------

// File: rtl/count_dir_pkg.sv
// rtl/count_dir_pkg.sv - shared types, constants and code arithmetic for the count direction decoder
//
// Contents:
//   dec_state_t - decoder FSM states (IDLE, TRACK, FAULT)
//   DIR_UP / DIR_DOWN - direction encoding, matching the counter's direction input
//   CODE_W - width of the counter code
//   code_delta() - 2-bit modular difference a - b between two counter codes
package count_dir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } dec_state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  localparam int   CODE_W   = 2;

  // Modulo-4 subtraction falls out of the 2-bit truncation, so 3->0 yields 1
  // (up) and 0->3 yields 3 (down).
  function automatic logic [CODE_W-1:0] code_delta(input logic [CODE_W-1:0] a,
                                                   input logic [CODE_W-1:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/count_sync2.sv
// rtl/count_sync2.sv - two-flop synchroniser per bit with asynchronous active-low reset
//
// Ports:
//   clk   - destination clock
//   reset - asynchronous active-low reset; both flop stages clear to 0
//   d     - asynchronous input bus
//   q     - synchronised output bus, two clk cycles behind d
module count_sync2 #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/count_direction_decoder.sv
// rtl/count_direction_decoder.sv - recovers step direction and signed position from a 2-bit up/down counter code
//
// Optional feature macro: CODE_SYNC_EN (count_in passes through count_sync2 first;
// latency grows from 1 to 3 cycles).
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   count_in   - counter code {Q_B, Q_A}
//   clear      - synchronous clear of position, overflow and fault (active-high)
//   locked     - reference code captured, tracking
//   step_valid - one-cycle pulse per legal step
//   dir        - direction of last legal step (0 up, 1 down), held between steps
//   position   - signed net step count since reset/clear
//   overflow   - sticky limit hit (SATURATE=1) or wrap (SATURATE=0)
//   error      - high while in FAULT
module count_direction_decoder
  import count_dir_pkg::*;
#(
  parameter int POS_W    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CODE_W-1:0]       count_in,
  input  logic                    clear,
  output logic                    locked,
  output logic                    step_valid,
  output logic                    dir,
  output logic signed [POS_W-1:0] position,
  output logic                    overflow,
  output logic                    error
);

  localparam logic [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
  localparam logic [POS_W-1:0] POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};

  logic [CODE_W-1:0] code;

`ifdef CODE_SYNC_EN
  count_sync2 #(.W(CODE_W)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (count_in),
    .q     (code)
  );
`else
  assign code = count_in;
`endif

  dec_state_t        state, state_nxt;
  logic [CODE_W-1:0] last_code, last_code_nxt;
  logic [CODE_W-1:0] delta;
  logic              locked_nxt, step_valid_nxt, dir_nxt, overflow_nxt, error_nxt;
  logic [POS_W-1:0]  position_nxt;

  assign delta = code_delta(code, last_code);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; clear overrides everything, including a fault.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_nxt = TRACK;
        TRACK:   if (delta == 2'd2) state_nxt = FAULT;
        FAULT:   state_nxt = FAULT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output / datapath next values; every output is registered below.
  always_comb begin
    last_code_nxt  = last_code;
    locked_nxt     = locked;
    step_valid_nxt = 1'b0;
    dir_nxt        = dir;
    position_nxt   = position;
    overflow_nxt   = overflow;
    error_nxt      = error;
    if (clear) begin
      position_nxt = '0;
      overflow_nxt = 1'b0;
      error_nxt    = 1'b0;
      locked_nxt   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          last_code_nxt = code;
          locked_nxt    = 1'b1;
        end
        TRACK: begin
          last_code_nxt = code;
          unique case (delta)
            2'd1: begin
              step_valid_nxt = 1'b1;
              dir_nxt        = DIR_UP;
              if (position == POS_MAX) begin
                overflow_nxt = 1'b1;
                if (!SATURATE) position_nxt = position + POS_ONE;
              end else begin
                position_nxt = position + POS_ONE;
              end
            end
            2'd3: begin
              step_valid_nxt = 1'b1;
              dir_nxt        = DIR_DOWN;
              if (position == POS_MIN) begin
                overflow_nxt = 1'b1;
                if (!SATURATE) position_nxt = position - POS_ONE;
              end else begin
                position_nxt = position - POS_ONE;
              end
            end
            2'd2: begin
              error_nxt  = 1'b1;
              locked_nxt = 1'b0;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_code  <= '0;
      locked     <= 1'b0;
      step_valid <= 1'b0;
      dir        <= 1'b0;
      position   <= '0;
      overflow   <= 1'b0;
      error      <= 1'b0;
    end else begin
      last_code  <= last_code_nxt;
      locked     <= locked_nxt;
      step_valid <= step_valid_nxt;
      dir        <= dir_nxt;
      position   <= position_nxt;
      overflow   <= overflow_nxt;
      error      <= error_nxt;
    end
  end

endmodule

// File: tb/tb_count_direction_decoder.sv
// tb/tb_count_direction_decoder.sv - directed self-checking bench for count_direction_decoder
module tb_count_direction_decoder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;
  logic [1:0] cin0 = 2'd2;
  logic [1:0] cin1 = 2'd0;

  logic locked0, sv0, dir0, ov0, err0;
  logic signed [15:0] pos0;
  logic locked1, sv1, dir1, ov1, err1;
  logic signed [3:0] pos1;
  logic locked2, sv2, dir2, ov2, err2;
  logic signed [3:0] pos2;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses0 = 0, pulses1 = 0, pulses2 = 0;
  int p0, p1;
  logic [1:0] c;

  always #5 clk = ~clk;

  count_direction_decoder #(.POS_W(16), .SATURATE(1'b1)) dut0 (
    .clk(clk), .reset(reset), .count_in(cin0), .clear(clear),
    .locked(locked0), .step_valid(sv0), .dir(dir0), .position(pos0),
    .overflow(ov0), .error(err0)
  );

  count_direction_decoder #(.POS_W(4), .SATURATE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .count_in(cin1), .clear(1'b0),
    .locked(locked1), .step_valid(sv1), .dir(dir1), .position(pos1),
    .overflow(ov1), .error(err1)
  );

  count_direction_decoder #(.POS_W(4), .SATURATE(1'b0)) dut2 (
    .clk(clk), .reset(reset), .count_in(cin1), .clear(1'b0),
    .locked(locked2), .step_valid(sv2), .dir(dir2), .position(pos2),
    .overflow(ov2), .error(err2)
  );

  // step_valid is high for exactly one full cycle, so it spans exactly one negedge.
  always @(negedge clk) begin
    if (sv0) pulses0++;
    if (sv1) pulses1++;
    if (sv2) pulses2++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive/sample 1 time unit after the falling edge, away from the rising edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    tick(1);
    check("rst_locked", int'(locked0), 0);
    check("rst_step_valid", int'(sv0), 0);
    check("rst_position", int'(pos0), 0);
    check("rst_err_ovf_dir", int'({err0, ov0, dir0}), 0);

    reset = 1'b1;
    tick(1);
    check("lock_locked", int'(locked0), 1);
    check("lock_no_step", int'(sv0), 0);
    check("lock_position", int'(pos0), 0);

    // Up 2 -> 3,0,1,2
    p0 = pulses0;
    c = 2'd2;
    for (int i = 0; i < 4; i++) begin
      c = c + 2'd1;
      cin0 = c;
      tick(1);
      check("up_step_valid", int'(sv0), 1);
    end
    check("up_pulses", pulses0 - p0, 4);
    check("up_dir", int'(dir0), 0);
    check("up_position", int'(pos0), 4);

    // Down 2 -> 1,0,3
    p0 = pulses0;
    for (int i = 0; i < 3; i++) begin
      c = c - 2'd1;
      cin0 = c;
      tick(1);
    end
    check("down_pulses", pulses0 - p0, 3);
    check("down_dir", int'(dir0), 1);
    check("down_position", int'(pos0), 1);

    // Hold code 3
    p0 = pulses0;
    tick(5);
    check("hold_pulses", pulses0 - p0, 0);
    check("hold_position", int'(pos0), 1);

    // 3 -> 2 -> 1, then illegal jump 1 -> 3
    cin0 = 2'd2; tick(1);
    cin0 = 2'd1; tick(1);
    check("pre_fault_position", int'(pos0), -1);
    cin0 = 2'd3; tick(1);
    check("fault_error", int'(err0), 1);
    check("fault_locked", int'(locked0), 0);
    check("fault_position", int'(pos0), -1);
    p0 = pulses0;
    cin0 = 2'd0; tick(1);
    cin0 = 2'd1; tick(1);
    check("fault_ignored_pulses", pulses0 - p0, 0);
    check("fault_ignored_position", int'(pos0), -1);
    check("fault_sticky_error", int'(err0), 1);

    clear = 1'b1; tick(1);
    clear = 1'b0;
    check("clear_position", int'(pos0), 0);
    check("clear_error", int'(err0), 0);
    check("clear_locked", int'(locked0), 0);
    tick(1);
    check("relock_locked", int'(locked0), 1);
    check("relock_no_step", int'(sv0), 0);

    // Saturation / wrap at POS_W=4: nine up steps from code 0
    p1 = pulses1;
    c = 2'd0;
    for (int i = 0; i < 9; i++) begin
      c = c + 2'd1;
      cin1 = c;
      tick(1);
    end
    check("sat_position", int'(pos1), 7);
    check("sat_overflow", int'(ov1), 1);
    check("sat_pulses", pulses1 - p1, 9);
    check("wrap_position", int'(pos2), -7);
    check("wrap_overflow", int'(ov2), 1);
    check("wrap_pulses", pulses2 - p1, 9);

    // Sixteen down steps: saturating copy clamps at -8, wrapping copy comes back to -7
    p1 = pulses1;
    for (int i = 0; i < 16; i++) begin
      c = c - 2'd1;
      cin1 = c;
      tick(1);
      if (i == 0) check("sat_ovf_sticky", int'({ov1, pos1}), int'({1'b1, 4'sd6}));
    end
    check("sat_min_position", int'(pos1), -8);
    check("sat_min_dir", int'(dir1), 1);
    check("sat_min_pulses", pulses1 - p1, 16);
    check("wrap_down_position", int'(pos2), -7);

    // dut0 at code 1, position 0: climb to 6 then down to 5
    for (int i = 0; i < 6; i++) begin
      cin0 = cin0 + 2'd1;
      tick(1);
    end
    cin0 = cin0 - 2'd1;
    tick(1);
    check("pre_reset_position", int'(pos0), 5);
    check("pre_reset_dir", int'(dir0), 1);

    // Asynchronous reset mid-sequence, checked before the next rising edge
    reset = 1'b0;
    #1;
    check("async_rst_position", int'(pos0), 0);
    check("async_rst_flags", int'({locked0, dir0, ov0, err0, sv0}), 0);
    check("async_rst_small", int'({locked1, ov1, pos1}), 0);
    cin0 = cin0 + 2'd1;
    tick(1);
    p0 = pulses0;
    reset = 1'b1;
    tick(1);
    check("post_rst_locked", int'(locked0), 1);
    check("post_rst_position", int'(pos0), 0);
    check("post_rst_no_step", pulses0 - p0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
